// File: rtl/sokoban_pkg.sv
// ---------------------------------------------------------------------------
// sokoban_pkg
// Definitions shared between the PS/2 front end and the Sokoban game core:
//   - PS/2 set-2 scan codes for W/A/S/D, the arrow keys and the E0/F0 prefixes
//   - one-hot move encodings carried on dirMove
//   - the receiver state type and a scan-code-to-direction lookup
// No ports (package).
// ---------------------------------------------------------------------------
package sokoban_pkg;

    localparam logic [7:0] SC_W     = 8'h1D;
    localparam logic [7:0] SC_A     = 8'h1C;
    localparam logic [7:0] SC_S     = 8'h1B;
    localparam logic [7:0] SC_D     = 8'h23;
    localparam logic [7:0] SC_UP    = 8'h75;
    localparam logic [7:0] SC_DOWN  = 8'h72;
    localparam logic [7:0] SC_LEFT  = 8'h6B;
    localparam logic [7:0] SC_RIGHT = 8'h74;
    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_BRK   = 8'hF0;

    localparam logic [3:0] DIR_NONE  = 4'b0000;
    localparam logic [3:0] DIR_UP    = 4'b0001;
    localparam logic [3:0] DIR_DOWN  = 4'b0010;
    localparam logic [3:0] DIR_LEFT  = 4'b0100;
    localparam logic [3:0] DIR_RIGHT = 4'b1000;

    typedef enum logic [1:0] {
        RX_IDLE   = 2'd0,
        RX_DATA   = 2'd1,
        RX_PARITY = 2'd2,
        RX_STOP   = 2'd3
    } rx_state_t;

    // Arrow codes map with or without the E0 prefix (the bare form is the
    // numeric keypad). Letter keys only map when no E0 prefix is pending.
    function automatic logic [3:0] scan_to_dir(input logic [7:0] code,
                                               input logic       ext);
        logic [3:0] dir;
        dir = DIR_NONE;
        case (code)
            SC_UP:    dir = DIR_UP;
            SC_DOWN:  dir = DIR_DOWN;
            SC_LEFT:  dir = DIR_LEFT;
            SC_RIGHT: dir = DIR_RIGHT;
            SC_W:     if (!ext) dir = DIR_UP;
            SC_S:     if (!ext) dir = DIR_DOWN;
            SC_A:     if (!ext) dir = DIR_LEFT;
            SC_D:     if (!ext) dir = DIR_RIGHT;
            default:  dir = DIR_NONE;
        endcase
        return dir;
    endfunction

endpackage

// File: rtl/ps2_rx.sv
// ---------------------------------------------------------------------------
// ps2_rx
// PS/2 device-to-host byte receiver. Synchronises the raw PS/2 lines, detects
// falling edges of ps2_clk and assembles 11-bit frames (start, 8 data LSB
// first, odd parity, stop). A partial frame that stalls for TIMEOUT_CYC clk
// cycles is dropped.
// Ports:
//   clk        in   system/pixel clock
//   reset      in   asynchronous active-low reset
//   ps2_clk    in   raw PS/2 clock (async)
//   ps2_data   in   raw PS/2 data (async)
//   key_code   out  last parity-good byte
//   key_strobe out  1-cycle pulse when key_code updates
//   frame_err  out  1-cycle pulse on parity/stop error or timeout
//
// state     | meaning
// ----------+-----------------------------------------------------------
// RX_IDLE   | waiting for a start bit (data low on a ps2_clk fall)
// RX_DATA   | shifting in the 8 data bits, LSB first
// RX_PARITY | capturing the parity bit and checking odd parity
// RX_STOP   | checking the stop bit, then publishing the byte or an error
// ---------------------------------------------------------------------------
module ps2_rx
    import sokoban_pkg::*;
#(
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] key_code,
    output logic       key_strobe,
    output logic       frame_err
);

    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    // [1:0] is the two-flop synchroniser, [2] the previous synchronised value
    logic [2:0]    clk_sync;
    logic [1:0]    data_sync;
    logic          ps2_fall;
    logic          data_s;

    rx_state_t     state, state_nxt;
    logic [2:0]    bitcnt, bitcnt_nxt;
    logic [7:0]    shreg, shreg_nxt;
    logic          par_ok, par_ok_nxt;
    logic [TW-1:0] tmo_cnt, tmo_nxt;
    logic [7:0]    code_nxt;
    logic          strobe_nxt, err_nxt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            clk_sync  <= 3'b111;
            data_sync <= 2'b11;
        end else begin
            clk_sync  <= {clk_sync[1:0], ps2_clk};
            data_sync <= {data_sync[0], ps2_data};
        end
    end

    assign ps2_fall = clk_sync[2] & ~clk_sync[1];
    assign data_s   = data_sync[1];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= RX_IDLE;
            bitcnt     <= 3'd0;
            shreg      <= 8'h00;
            par_ok     <= 1'b0;
            tmo_cnt    <= '0;
            key_code   <= 8'h00;
            key_strobe <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            state      <= state_nxt;
            bitcnt     <= bitcnt_nxt;
            shreg      <= shreg_nxt;
            par_ok     <= par_ok_nxt;
            tmo_cnt    <= tmo_nxt;
            key_code   <= code_nxt;
            key_strobe <= strobe_nxt;
            frame_err  <= err_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        bitcnt_nxt = bitcnt;
        shreg_nxt  = shreg;
        par_ok_nxt = par_ok;
        tmo_nxt    = tmo_cnt;
        code_nxt   = key_code;
        strobe_nxt = 1'b0;
        err_nxt    = 1'b0;

        // Down-counter reloads on every falling edge and parks at zero, so a
        // long stall can never wrap around and hide the timeout.
        if (state != RX_IDLE && !ps2_fall) begin
            if (tmo_cnt == '0) begin
                state_nxt = RX_IDLE;
                err_nxt   = 1'b1;
            end else begin
                tmo_nxt = tmo_cnt - 1'b1;
            end
        end

        if (ps2_fall) begin
            tmo_nxt = TW'(TIMEOUT_CYC - 1);
            case (state)
                RX_IDLE: begin
                    if (!data_s) begin
                        state_nxt  = RX_DATA;
                        bitcnt_nxt = 3'd0;
                    end
                end
                RX_DATA: begin
                    shreg_nxt  = {data_s, shreg[7:1]};
                    bitcnt_nxt = bitcnt + 3'd1;
                    if (bitcnt == 3'd7) state_nxt = RX_PARITY;
                end
                RX_PARITY: begin
                    par_ok_nxt = ^{shreg, data_s};
                    state_nxt  = RX_STOP;
                end
                RX_STOP: begin
                    if (data_s && par_ok) begin
                        code_nxt   = shreg;
                        strobe_nxt = 1'b1;
                    end else begin
                        err_nxt = 1'b1;
                    end
                    state_nxt = RX_IDLE;
                end
                default: state_nxt = RX_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/ps2_dir_decoder.sv
// ---------------------------------------------------------------------------
// ps2_dir_decoder
// PS/2 keyboard front end for the Sokoban game core. Receives scan bytes,
// tracks E0/F0 prefixes, turns W/A/S/D and arrow make codes into a one-hot
// move request on dirMove, and clears that request on the first vs rising
// edge after it is raised (the game core samples dirMove on posedge vs).
// Ports:
//   clk        in   pixel clock, shared with the game core
//   reset      in   asynchronous active-low reset
//   ps2_clk    in   raw PS/2 clock (async)
//   ps2_data   in   raw PS/2 data (async)
//   vs         in   VGA frame sync (async, synchronised here)
//   dirMove    out  one-hot move request, 0000 when none pending
//   key_code   out  last parity-good scan byte
//   key_strobe out  1-cycle pulse when key_code updates
//   frame_err  out  1-cycle pulse on parity/stop error or timeout
// ---------------------------------------------------------------------------
module ps2_dir_decoder
    import sokoban_pkg::*;
#(
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic       vs,
    output logic [3:0] dirMove,
    output logic [7:0] key_code,
    output logic       key_strobe,
    output logic       frame_err
);

    logic [2:0] vs_sync;
    logic       vs_rise;

    logic       e0_seen, e0_nxt;
    logic       f0_seen, f0_nxt;
    logic [3:0] held_dir, held_nxt;
    logic [3:0] dir_nxt;
    logic [3:0] mapped;

    ps2_rx #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_rx (
        .clk        (clk),
        .reset      (reset),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .key_code   (key_code),
        .key_strobe (key_strobe),
        .frame_err  (frame_err)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vs_sync <= 3'b000;
        end else begin
            vs_sync <= {vs_sync[1:0], vs};
        end
    end

    assign vs_rise = vs_sync[1] & ~vs_sync[2];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            e0_seen  <= 1'b0;
            f0_seen  <= 1'b0;
            held_dir <= DIR_NONE;
            dirMove  <= DIR_NONE;
        end else begin
            e0_seen  <= e0_nxt;
            f0_seen  <= f0_nxt;
            held_dir <= held_nxt;
            dirMove  <= dir_nxt;
        end
    end

    // held_dir remembers the key currently down so typematic repeats do not
    // generate extra moves; dirMove is the one-shot request to the core.
    // A make arriving in the same cycle as the vs clear takes priority.
    always_comb begin
        e0_nxt   = e0_seen;
        f0_nxt   = f0_seen;
        held_nxt = held_dir;
        dir_nxt  = dirMove;
        mapped   = DIR_NONE;

        if (vs_rise) dir_nxt = DIR_NONE;

        if (key_strobe) begin
            if (key_code == SC_EXT) begin
                e0_nxt = 1'b1;
            end else if (key_code == SC_BRK) begin
                f0_nxt = 1'b1;
            end else begin
                mapped = scan_to_dir(key_code, e0_seen);
                e0_nxt = 1'b0;
                f0_nxt = 1'b0;
                if (mapped != DIR_NONE) begin
                    if (f0_seen) begin
                        if (held_dir == mapped) held_nxt = DIR_NONE;
                    end else if (held_dir != mapped) begin
                        held_nxt = mapped;
                        dir_nxt  = mapped;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_ps2_dir_decoder.sv
module tb_ps2_dir_decoder;

    localparam int TMO = 300;

    logic       clk;
    logic       reset;
    logic       ps2_clk;
    logic       ps2_data;
    logic       vs;
    logic [3:0] dirMove;
    logic [7:0] key_code;
    logic       key_strobe;
    logic       frame_err;

    int errors = 0;
    int checks = 0;
    int strobes = 0;
    int errs = 0;
    int onehot_bad = 0;

    ps2_dir_decoder #(
        .TIMEOUT_CYC (TMO)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .vs         (vs),
        .dirMove    (dirMove),
        .key_code   (key_code),
        .key_strobe (key_strobe),
        .frame_err  (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (reset) begin
            if (key_strobe) strobes++;
            if (frame_err) errs++;
            if (!(dirMove inside {4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000}))
                onehot_bad++;
        end
    end

    // ---------------- behavioural reference model ----------------
    logic [7:0] letter_codes [4] = '{8'h1D, 8'h1B, 8'h1C, 8'h23};
    logic [7:0] arrow_codes  [4] = '{8'h75, 8'h72, 8'h6B, 8'h74};
    logic       m_e0, m_f0;
    logic [3:0] m_held, m_dir;
    logic [7:0] m_code;

    task automatic model_reset();
        m_e0 = 0; m_f0 = 0; m_held = 0; m_dir = 0; m_code = 8'h00;
    endtask

    task automatic model_byte(input logic [7:0] b, input int corrupt);
        logic [3:0] d;
        if (corrupt != 0) return;
        m_code = b;
        if (b == 8'hE0) begin
            m_e0 = 1;
        end else if (b == 8'hF0) begin
            m_f0 = 1;
        end else begin
            d = 0;
            for (int i = 0; i < 4; i++)
                if (b == arrow_codes[i] || (!m_e0 && b == letter_codes[i]))
                    d = 4'(1 << i);
            if (d != 0) begin
                if (m_f0) begin
                    if (m_held == d) m_held = 0;
                end else if (m_held != d) begin
                    m_held = d;
                    m_dir = d;
                end
            end
            m_e0 = 0;
            m_f0 = 0;
        end
    endtask

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        @(posedge clk) ps2_data = b;
        repeat (5) @(posedge clk);
        ps2_clk = 0;
        repeat (10) @(posedge clk);
        ps2_clk = 1;
        repeat (5) @(posedge clk);
    endtask

    // corrupt: 0 clean, 1 flipped parity, 2 stop bit low
    task automatic send_frame(input logic [7:0] b, input int corrupt);
        logic par;
        par = ~^b;
        if (corrupt == 1) par = ~par;
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(par);
        send_bit(corrupt == 2 ? 1'b0 : 1'b1);
        ps2_data = 1;
        repeat (10) @(posedge clk);
    endtask

    task automatic pulse_vs(input string name);
        @(posedge clk) vs = 1;
        repeat (6) @(posedge clk);
        m_dir = 0;
        check(name, dirMove, 4'b0000);
        vs = 0;
        repeat (4) @(posedge clk);
    endtask

    typedef struct {
        logic [7:0] code;
        int         corrupt;
        bit         do_vs;
        logic [3:0] exp_dir;
        logic [7:0] exp_code;
        int         exp_strobe;
        int         exp_err;
    } vec_t;

    vec_t vecs[$];

    initial begin
        int s0, e0c, cyc;
        logic [7:0] pool [11] = '{8'h1D, 8'h1B, 8'h1C, 8'h23, 8'h75, 8'h72,
                                  8'h6B, 8'h74, 8'hE0, 8'hF0, 8'h00};
        reset = 0; ps2_clk = 1; ps2_data = 1; vs = 0;
        model_reset();

        vecs.push_back('{8'h1D, 0, 1, 4'b0001, 8'h1D, 1, 0});
        vecs.push_back('{8'hE0, 0, 1, 4'b0000, 8'hE0, 1, 0});
        vecs.push_back('{8'h74, 0, 1, 4'b1000, 8'h74, 1, 0});
        for (int k = 0; k < 3; k++) begin
            vecs.push_back('{8'hE0, 0, 0, 4'b0000, 8'hE0, 1, 0});
            vecs.push_back('{8'h74, 0, 1, 4'b0000, 8'h74, 1, 0});
        end
        vecs.push_back('{8'hE0, 0, 0, 4'b0000, 8'hE0, 1, 0});
        vecs.push_back('{8'hF0, 0, 0, 4'b0000, 8'hF0, 1, 0});
        vecs.push_back('{8'h74, 0, 0, 4'b0000, 8'h74, 1, 0});
        vecs.push_back('{8'hE0, 0, 0, 4'b0000, 8'hE0, 1, 0});
        vecs.push_back('{8'h74, 0, 1, 4'b1000, 8'h74, 1, 0});
        vecs.push_back('{8'h1C, 1, 0, 4'b0000, 8'h74, 0, 1});
        vecs.push_back('{8'h1C, 2, 0, 4'b0000, 8'h74, 0, 1});
        vecs.push_back('{8'h1D, 0, 0, 4'b0001, 8'h1D, 1, 0});
        vecs.push_back('{8'h1B, 0, 1, 4'b0010, 8'h1B, 1, 0});
        vecs.push_back('{8'hE0, 0, 0, 4'b0000, 8'hE0, 1, 0});
        vecs.push_back('{8'h1C, 1, 0, 4'b0000, 8'hE0, 0, 1});
        vecs.push_back('{8'h1D, 0, 0, 4'b0000, 8'h1D, 1, 0});
        vecs.push_back('{8'h75, 0, 1, 4'b0001, 8'h75, 1, 0});
        vecs.push_back('{8'h6B, 0, 1, 4'b0100, 8'h6B, 1, 0});

        repeat (3) @(posedge clk);
        #1;
        check("reset_dir", dirMove, 4'b0000);
        check("reset_code", key_code, 8'h00);
        check("reset_flags", {key_strobe, frame_err}, 2'b00);
        @(negedge clk) reset = 1;
        repeat (5) @(posedge clk);

        foreach (vecs[i]) begin
            s0 = strobes; e0c = errs;
            send_frame(vecs[i].code, vecs[i].corrupt);
            model_byte(vecs[i].code, vecs[i].corrupt);
            check($sformatf("vec%0d_dir", i), dirMove, vecs[i].exp_dir);
            check($sformatf("vec%0d_model", i), m_dir, vecs[i].exp_dir);
            check($sformatf("vec%0d_code", i), key_code, vecs[i].exp_code);
            check($sformatf("vec%0d_strobe", i), strobes - s0, vecs[i].exp_strobe);
            check($sformatf("vec%0d_err", i), errs - e0c, vecs[i].exp_err);
            if (vecs[i].do_vs) pulse_vs($sformatf("vec%0d_vsclr", i));
        end

        // partial frame: start + 4 data bits, then silence
        s0 = strobes; e0c = errs;
        send_bit(1'b0);
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        @(posedge clk) ps2_data = 0;
        repeat (5) @(posedge clk);
        ps2_clk = 0;
        cyc = 0;
        while (errs == e0c && cyc < 3 * TMO) begin
            @(posedge clk);
            cyc++;
            if (cyc == 10) begin ps2_clk = 1; ps2_data = 1; end
        end
        check("timeout_err", errs - e0c, 1);
        check("timeout_window", (cyc >= TMO && cyc <= TMO + 8), 1);
        check("timeout_nostrobe", strobes - s0, 0);
        repeat (5) @(posedge clk);
        send_frame(8'h23, 0);
        model_byte(8'h23, 0);
        check("after_timeout_dir", dirMove, 4'b1000);
        check("after_timeout_code", key_code, 8'h23);
        pulse_vs("after_timeout_vsclr");

        // reset mid-frame with a pending request
        send_frame(8'h1B, 0);
        model_byte(8'h1B, 0);
        check("pre_reset_dir", dirMove, 4'b0010);
        send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
        @(posedge clk) ps2_data = 0;
        repeat (3) @(posedge clk);
        ps2_clk = 0;
        #2 reset = 0;
        #1;
        check("midreset_dir", dirMove, 4'b0000);
        check("midreset_code", key_code, 8'h00);
        check("midreset_flags", {key_strobe, frame_err}, 2'b00);
        ps2_clk = 1; ps2_data = 1;
        repeat (4) @(posedge clk);
        @(negedge clk) reset = 1;
        model_reset();
        repeat (5) @(posedge clk);
        s0 = strobes; e0c = errs;
        send_frame(8'h1B, 0);
        model_byte(8'h1B, 0);
        check("post_reset_dir", dirMove, 4'b0010);
        check("post_reset_code", key_code, 8'h1B);
        check("post_reset_counts", {strobes - s0, errs - e0c}, {32'd1, 32'd0});
        pulse_vs("post_reset_vsclr");

        // randomized frames against the model
        for (int n = 0; n < 60; n++) begin
            logic [7:0] b;
            int corrupt, r;
            b = pool[$urandom_range(0, 10)];
            if (b == 8'h00) b = 8'($urandom_range(0, 255));
            r = $urandom_range(0, 19);
            corrupt = (r == 0) ? 1 : (r == 1) ? 2 : 0;
            s0 = strobes; e0c = errs;
            send_frame(b, corrupt);
            model_byte(b, corrupt);
            check($sformatf("rnd%0d_dir", n), dirMove, m_dir);
            check($sformatf("rnd%0d_code", n), key_code, m_code);
            check($sformatf("rnd%0d_counts", n), {strobes - s0, errs - e0c},
                  {32'(corrupt == 0), 32'(corrupt != 0)});
            if ($urandom_range(0, 2) == 0) pulse_vs($sformatf("rnd%0d_vsclr", n));
        end

        check("onehot_violations", onehot_bad, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
